debug_trace_buffer: RTL and testbench
=====================================

DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the captured CPU debug word.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port debug_in  input  DATA_W  debug word from single_cycle_cpu debug_out.
REQ-006 SHALL have port capture_en  input  1  enables change-detect capture.
REQ-007 SHALL have port out_valid  output  1  head entry available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-009 SHALL have port out_data  output  DATA_W  head entry value.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-012 SHALL hold a prev register and has_prev flag; when capture_en=1, prev<=debug_in and has_prev<=1 each cycle.
REQ-013 SHALL generate push when capture_en=1 and (has_prev=0 or debug_in!=prev); no push when capture_en=0.
REQ-014 SHALL write a pushed word at wr_ptr on the same edge; out_valid and out_data reflect it from the next cycle (latency 1 when empty).
REQ-015 SHALL be first-word-fall-through: out_data=mem[rd_ptr] whenever out_valid=1.
REQ-016 SHALL pop when out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive out_valid=(level!=0); out_ready is ignored when empty.
REQ-018 SHALL wrap wr_ptr and rd_ptr modulo DEPTH.
REQ-019 SHALL, on push and pop in the same cycle, keep level unchanged, including when full (pop frees the slot, push accepted).
REQ-020 SHALL, on push when level=DEPTH without pop, drop the word, leave contents unchanged, and set overflow=1.
REQ-021 SHALL keep overflow=1 until rst; no other clear.
REQ-022 SHALL on push with level=0 and pop asserted ignore the pop (nothing to pop); level becomes 1.

Reset
REQ-023 SHALL on rst=1 at a clock edge set wr_ptr=0, rd_ptr=0, level=0, overflow=0, has_prev=0, prev=0; out_valid=0 next cycle.
REQ-024 SHALL discard FIFO contents on reset mid-operation; memory array need not be cleared.
REQ-025 SHALL ignore push and pop in any cycle with rst=1.

Configuration
REQ-026 SHALL, with macro DEBUG_TRACE_TIMESTAMP_EN defined, add port out_ts  output  32  cycle stamp of head entry, and a 32-bit cycle counter reset to 0, +1 every cycle, wrapping 0xFFFFFFFF->0.
REQ-027 SHALL, with DEBUG_TRACE_TIMESTAMP_EN defined, store the counter value of the push cycle alongside each entry; out_ts follows REQ-015/016 like out_data.
REQ-028 SHALL, without DEBUG_TRACE_TIMESTAMP_EN, omit out_ts, counter and timestamp storage; all other behaviour identical.

Verification
REQ-029 SHALL cover: rst 2 cycles, capture_en=1, debug_in=0x5 held 4 cycles, out_ready=0 -> level=1, out_data=0x5, out_valid from cycle after first capture.
REQ-030 SHALL cover: debug_in 0x1,0x1,0x2,0x3,0x3 with out_ready=0 -> level=3, pops in order 0x1,0x2,0x3, then out_valid=0.
REQ-031 SHALL cover: 17 distinct values, DEPTH=16, out_ready=0 -> level=16, overflow=1, head=first value; 16 pops return values 1..16; overflow stays 1.
REQ-032 SHALL cover: full FIFO, new value pushed with out_ready=1 -> level stays 16, overflow stays 0, last pop returns new value.
REQ-033 SHALL cover: level=5, rst pulsed 1 cycle -> level=0, out_valid=0, overflow=0; next debug_in 0xA captured as first entry.
REQ-034 SHALL cover (DEBUG_TRACE_TIMESTAMP_EN): rst release at counter 0, changes at cycles 3 and 7 -> out_ts=3 then 7.

Source files
------------

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
// Captures the CPU debug word whenever it changes (while capture_en is high)
// into a first-word-fall-through FIFO. Once the FIFO is full, further captures
// are dropped and the sticky overflow flag is set.
// Optional feature: define DEBUG_TRACE_TIMESTAMP_EN to store a 32-bit cycle
// stamp with each entry. The stamp of the head entry appears on out_ts.
module debug_trace_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       debug_in,
  input  logic                    capture_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]             out_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] prev_r;
  logic              has_prev_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              valid_r;
  logic              overflow_r;

  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [LW-1:0]     level_nxt_s;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [31:0]       ts_cnt_r;
  logic [31:0]       ts_mem_r [DEPTH];
`endif

  // Push/pop decode. A cycle with rst high neither pushes nor pops.
  // A pop is only possible when the FIFO is not empty.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    wr_en_s     = 1'b0;
    drop_s      = 1'b0;
    level_nxt_s = level_r;
    if (rst) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = capture_en && (!has_prev_r || (debug_in != prev_r));
      pop_s  = valid_r && out_ready;
    end
    // When the FIFO is full, a simultaneous pop frees the slot for the push.
    if (push_s && ((level_r != FULL_LEVEL) || pop_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    drop_s = push_s && !wr_en_s;
    case ({wr_en_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Control state: change-detect history, pointers, fill level and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r     <= {DATA_W{1'b0}};
      has_prev_r <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (capture_en) begin
        prev_r     <= debug_in;
        has_prev_r <= 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != {LW{1'b0}});
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage. It is left uncleared on reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= debug_in;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = mem_r[rd_ptr_r];
  assign level     = level_r;
  assign overflow  = overflow_r;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  // Free-running cycle counter. It wraps from 0xFFFFFFFF to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_r <= 32'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
    end
  end

  // Stamp storage, written alongside the data entry.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ts_mem_r[wr_ptr_r] <= ts_cnt_r;
    end
  end

  assign out_ts = ts_mem_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed self-checking bench for debug_trace_buffer (DATA_W=64, DEPTH=16).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled there too.
module tb_debug_trace_buffer;

  logic        clk;
  logic        rst;
  logic [63:0] debug_in;
  logic        capture_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  level;
  logic        overflow;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  int n_vec = 0;
  int n_err = 0;

  debug_trace_buffer #(.DATA_W(64), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .debug_in   (debug_in),
    .capture_en (capture_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .overflow   (overflow)
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    ,
    .out_ts     (out_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    capture_en = 1'b0;
    out_ready  = 1'b0;
    debug_in   = 64'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    capture_en = 1'b0;
    out_ready  = 1'b0;
    debug_in   = 64'h0;

    // Reset state
    do_reset();
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);

    // A held word is captured once
    capture_en = 1'b1;
    debug_in   = 64'h5;
    tick();
    check_eq("hold_valid1", 64'(out_valid), 64'd1);
    check_eq("hold_data1", out_data, 64'h5);
    tick(); tick(); tick();
    check_eq("hold_level", 64'(level), 64'd1);
    check_eq("hold_data", out_data, 64'h5);
    // Empty-FIFO rule: capture_en=0 pushes nothing, and out_data holds while not ready
    capture_en = 1'b0;
    debug_in   = 64'h77;
    tick();
    check_eq("noen_level", 64'(level), 64'd1);
    check_eq("stall_data", out_data, 64'h5);
    out_ready = 1'b1;
    tick();
    check_eq("pop_empty", 64'(out_valid), 64'd0);
    tick();
    check_eq("ready_empty_lvl", 64'(level), 64'd0);
    // Push into an empty FIFO with out_ready high: the pop is ignored
    capture_en = 1'b1;
    debug_in   = 64'h42;
    tick();
    check_eq("push_empty_lvl", 64'(level), 64'd1);
    check_eq("push_empty_data", out_data, 64'h42);

    // Change detect: 1,1,2,3,3 gives three entries
    do_reset();
    capture_en = 1'b1;
    debug_in = 64'h1; tick();
    debug_in = 64'h1; tick();
    debug_in = 64'h2; tick();
    debug_in = 64'h3; tick();
    debug_in = 64'h3; tick();
    check_eq("cd_level", 64'(level), 64'd3);
    capture_en = 1'b0;
    out_ready  = 1'b1;
    check_eq("cd_pop1", out_data, 64'h1); tick();
    check_eq("cd_pop2", out_data, 64'h2); tick();
    check_eq("cd_pop3", out_data, 64'h3); tick();
    check_eq("cd_empty", 64'(out_valid), 64'd0);

    // Overflow: 17 distinct values
    do_reset();
    capture_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      debug_in = 64'(i);
      tick();
    end
    check_eq("ovf_level", 64'(level), 64'd16);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_head", out_data, 64'h1);
    capture_en = 1'b0;
    out_ready  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_eq($sformatf("ovf_pop%0d", i), out_data, 64'(i));
      tick();
    end
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    check_eq("ovf_drained", 64'(out_valid), 64'd0);

    // Full FIFO with a simultaneous push and pop
    do_reset();
    check_eq("ovf_cleared", 64'(overflow), 64'd0);
    capture_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      debug_in = 64'(i);
      tick();
    end
    check_eq("full_level", 64'(level), 64'd16);
    debug_in  = 64'h99;
    out_ready = 1'b1;
    tick();
    check_eq("full_pp_level", 64'(level), 64'd16);
    check_eq("full_pp_ovf", 64'(overflow), 64'd0);
    capture_en = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      check_eq($sformatf("full_pop%0d", i), out_data, 64'(i));
      tick();
    end
    check_eq("full_last", out_data, 64'h99);
    tick();
    check_eq("full_empty", 64'(out_valid), 64'd0);

    // Reset in the middle of operation
    do_reset();
    capture_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      debug_in = 64'(i);
      tick();
    end
    check_eq("mid_level5", 64'(level), 64'd5);
    rst      = 1'b1;
    debug_in = 64'h6;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_level", 64'(level), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
    debug_in = 64'hA;
    tick();
    check_eq("mid_first_lvl", 64'(level), 64'd1);
    check_eq("mid_first_data", out_data, 64'hA);

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    // Timestamps: reset is released at counter 0, and the word changes at cycles 3 and 7
    do_reset();
    tick(); tick(); tick();
    capture_en = 1'b1;
    debug_in   = 64'h11;
    tick(); tick(); tick(); tick();
    debug_in = 64'h22;
    tick();
    capture_en = 1'b0;
    check_eq("ts_level", 64'(level), 64'd2);
    check_eq("ts_first", 64'(out_ts), 64'd3);
    out_ready = 1'b1;
    tick();
    check_eq("ts_second", 64'(out_ts), 64'd7);
    check_eq("ts_data2", out_data, 64'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
